// File: rtl/pcihellocore_led_pwm.sv
// pcihellocore_led_pwm: LED driver downstream of the green-LED PIO slave.
// It turns the 32-bit PIO word into per-LED PWM brightness with optional blinking.
// Host writes are snapshotted only at PWM period ends, so patterns never tear.
// Optional feature macro: LED_PWM_BLINK_EN (blink mask, blink rate and blink counter).
module pcihellocore_led_pwm #(
  parameter int NUM_LEDS = 8,
  parameter int PRESCALE = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [31:0]         in_word,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                period_strobe
);

  localparam int              PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  // Prescaler and PWM counter.
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
  logic             tick;
  logic             period_end;

  // Snapshot of the host word, split into the fields actually used.
  logic [NUM_LEDS-1:0] shadow_on_q, shadow_on_d;
  logic [7:0]          shadow_duty_q, shadow_duty_d;

  // Output stage.
  logic [NUM_LEDS-1:0] led_d;
  logic                pwm_on;
  logic                blink_phase;
  logic [NUM_LEDS-1:0] blink_gate;

  // Bits of the host word that are not stored in every build.
  logic unused_in_word;
  assign unused_in_word = ^in_word;

`ifdef LED_PWM_BLINK_EN
  logic [NUM_LEDS-1:0] shadow_blink_q, shadow_blink_d;
  logic [3:0]          shadow_rate_q, shadow_rate_d;
  logic [15:0]         blink_cnt_q, blink_cnt_d;

  // Blink snapshot fields and the period counter that drives the blink phase.
  always_comb begin
    shadow_blink_d = shadow_blink_q;
    shadow_rate_d  = shadow_rate_q;
    blink_cnt_d    = blink_cnt_q;
    if (period_end) begin
      shadow_blink_d = in_word[8 +: NUM_LEDS];
      shadow_rate_d  = in_word[27:24];
      blink_cnt_d    = blink_cnt_q + 16'd1;
    end
  end

  // Blink state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_blink_q <= '0;
      shadow_rate_q  <= '0;
      blink_cnt_q    <= '0;
    end else begin
      shadow_blink_q <= shadow_blink_d;
      shadow_rate_q  <= shadow_rate_d;
      blink_cnt_q    <= blink_cnt_d;
    end
  end

  assign blink_phase = blink_cnt_q[shadow_rate_q];
  assign blink_gate  = ~shadow_blink_q | {NUM_LEDS{blink_phase}};
`else
  assign blink_phase = 1'b1;
  assign blink_gate  = {NUM_LEDS{blink_phase}};
`endif

  // Prescaler wrap, PWM advance and period-end detection.
  always_comb begin
    tick       = (pre_cnt_q == PRE_MAX);
    pre_cnt_d  = tick ? '0 : pre_cnt_q + 1'b1;
    pwm_cnt_d  = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    period_end = tick && (pwm_cnt_q == 8'hFF);
  end

  // Snapshot load: the word present on the period-end cycle wins.
  always_comb begin
    shadow_on_d   = shadow_on_q;
    shadow_duty_d = shadow_duty_q;
    if (period_end) begin
      shadow_on_d   = in_word[NUM_LEDS-1:0];
      shadow_duty_d = in_word[23:16];
    end
  end

  // Lit decision from the snapshot and current PWM position only.
  always_comb begin
    pwm_on = (shadow_duty_q == 8'hFF) | (pwm_cnt_q < shadow_duty_q);
    led_d  = shadow_on_q & {NUM_LEDS{pwm_on}} & blink_gate;
  end

  // Counters, snapshot and registered outputs; reset darkens LEDs at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q     <= '0;
      pwm_cnt_q     <= '0;
      shadow_on_q   <= '0;
      shadow_duty_q <= '0;
      led_out       <= '0;
      period_strobe <= 1'b0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      shadow_on_q   <= shadow_on_d;
      shadow_duty_q <= shadow_duty_d;
      led_out       <= led_d;
      period_strobe <= period_end;
    end
  end

endmodule

// File: tb/tb_pcihellocore_led_pwm.sv
// Testbench for pcihellocore_led_pwm: two instances (PRESCALE=1 and PRESCALE=4)
// share reset and host word; a scoreboard queue holds per-cycle expectations
// derived from elapsed-cycle arithmetic, and a monitor compares on negedge.
module tb_pcihellocore_led_pwm;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_word;
  logic [7:0]  led1, led4;
  logic        stb1, stb4;

  always #5 clk = ~clk;

  pcihellocore_led_pwm #(.NUM_LEDS(8), .PRESCALE(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_word(in_word),
    .led_out(led1), .period_strobe(stb1));

  pcihellocore_led_pwm #(.NUM_LEDS(8), .PRESCALE(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .in_word(in_word),
    .led_out(led4), .period_strobe(stb4));

  typedef struct packed {
    logic       s1;
    logic [7:0] l1;
    logic       s4;
    logic [7:0] l4;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          n;            // clock edges since reset release
  logic [31:0] sh1, sh4;     // word captured at the latest period end
  bit          cnt_en;
  int          lit1, lit4, nstb1, nstb4;

`ifdef LED_PWM_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // LED pattern for a snapshot, PWM position and number of completed periods.
  function automatic logic [7:0] lit(input logic [31:0] sh, input int pwm, input int periods);
    int         duty;
    int         rate;
    bit         on_pwm;
    bit         phase;
    logic [7:0] r;
    duty   = int'(sh[23:16]);
    rate   = int'(sh[27:24]);
    on_pwm = (duty == 255) || (pwm < duty);
    phase  = (((periods % 65536) >> rate) & 1) == 1;
    for (int i = 0; i < 8; i++)
      r[i] = sh[i] && on_pwm && (!(BLINK_EN && sh[8+i]) || phase);
    return r;
  endfunction

  // Expected {strobe, led} after the edge that follows 'edges' elapsed edges.
  function automatic logic [8:0] model(input int edges, input int ps, input logic [31:0] sh);
    int plen;
    plen = 256 * ps;
    return {((edges + 1) % plen) == 0, lit(sh, (edges / ps) % 256, edges / plen)};
  endfunction

  // One clock of stimulus; expectation for the coming edge goes to the scoreboard.
  task automatic step(input logic [31:0] w);
    logic [8:0] e1, e4;
    exp_t       e;
    in_word = w;
    if (!reset_n) begin
      e1 = '0; e4 = '0; n = 0; sh1 = '0; sh4 = '0;
    end else begin
      e1 = model(n, 1, sh1);
      e4 = model(n, 4, sh4);
      if ((n + 1) % 256 == 0)  sh1 = w;
      if ((n + 1) % 1024 == 0) sh4 = w;
      n++;
    end
    @(posedge clk);
    e.s1 = e1[8]; e.l1 = e1[7:0]; e.s4 = e4[8]; e.l4 = e4[7:0];
    exp_q.push_back(e);
    #1;
    if (cnt_en) begin
      lit1  += int'(led1[0]);
      lit4  += int'(led4[0]);
      nstb1 += int'(stb1);
      nstb4 += int'(stb4);
    end
  endtask

  task automatic hold(input logic [31:0] w, input int cycles);
    repeat (cycles) step(w);
  endtask

  // Run until a period end of the given length has just captured w.
  task automatic align(input logic [31:0] w, input int plen);
    do step(w); while (n % plen != 0);
  endtask

  task automatic measure(input logic [31:0] w, input int cycles);
    lit1 = 0; lit4 = 0; nstb1 = 0; nstb4 = 0;
    cnt_en = 1'b1;
    hold(w, cycles);
    cnt_en = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("led_p1", {24'd0, led1}, {24'd0, e.l1});
      check("stb_p1", {31'd0, stb1}, {31'd0, e.s1});
      check("led_p4", {24'd0, led4}, {24'd0, e.l4});
      check("stb_p4", {31'd0, stb4}, {31'd0, e.s4});
    end
  end

  initial begin
    logic [31:0] w;
    cnt_en  = 1'b0;
    reset_n = 1'b0;
    in_word = '0;
    n = 0; sh1 = '0; sh4 = '0;
    hold(32'h0, 4);
    reset_n = 1'b1;

    // Dark until the first snapshot, one strobe, then fully lit.
    measure(32'h00FF00FF, 256);
    check("dark_first_period", lit1, 0);
    check("first_strobe", nstb1, 1);
    measure(32'h00FF00FF, 512);
    check("lit_after_snapshot", lit1, 512);
    check("strobes_two_periods", nstb1, 2);

    // Half duty on LEDs[3:0], then asynchronous reset mid-period.
    align(32'h0080000F, 256);
    measure(32'h0080000F, 256);
    check("half_duty_count", lit1, 128);
    hold(32'h0080000F, 60);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset_led_p1", {24'd0, led1}, 32'd0);
    check("async_reset_led_p4", {24'd0, led4}, 32'd0);
    check("async_reset_stb", {30'd0, stb1, stb4}, 32'd0);
    hold(32'h0080000F, 3);
    reset_n = 1'b1;

    // Several writes within one period: only the period-end value counts.
    align(32'h00FF0001, 256);
    hold(32'h00FF0001, 100);
    hold(32'h00FF0002, 50);
    hold(32'h00FF0004, 50);
    align(32'h00FF0004, 256);
    measure(32'h00FF0004, 256);
    check("old_led0_gone", lit1, 0);
    check("only_led2", {24'd0, led1}, 32'h4);

    // Duty boundaries.
    align(32'h000000FF, 256);
    measure(32'h000000FF, 256);
    check("duty_00", lit1, 0);
    align(32'h000100FF, 256);
    measure(32'h000100FF, 256);
    check("duty_01", lit1, 1);
    align(32'h00FF00FF, 256);
    measure(32'h00FF00FF, 256);
    check("duty_ff", lit1, 256);

    // Blink at rate 1 on the PRESCALE=4 instance.
    align(32'h01FFFF01, 1024);
    measure(32'h01FFFF01, 4096);
    check("blink_led0_count", lit4, BLINK_EN ? 2048 : 4096);
    check("strobes_p4", nstb4, 4);
    check("strobes_p1", nstb1, 16);

    // Randomized host words with biased duty choices.
    for (int k = 0; k < 15; k++) begin
      w = $urandom;
      case ($urandom_range(0, 3))
        0: w[23:16] = 8'h00;
        1: w[23:16] = 8'h01;
        2: w[23:16] = 8'hFF;
        default: ;
      endcase
      w[27:24] = 4'($urandom_range(0, 3));
      hold(w, $urandom_range(50, 1500));
    end

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
